// File: rtl/tristate_bus_master.sv
// tristate_bus_master: single-op initiator for the shared addressed tristate data bus
module tristate_bus_master #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int READ_WAIT  = 1,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic              bus_oe
);
  typedef enum logic [1:0] {IDLE, TURN, WRITE, READ} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic last_rd_q, last_rd_d, we_q, we_d, oe_q, oe_d, rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic accept, done_rd, smp_err;
  assign accept = state_q == IDLE && req_valid;
  assign done_rd = state_q == READ && cnt_q == 3'd0;
  assign smp_err = (bus_data === {DATA_W{1'bz}}) || $isunknown(bus_data);
  assign bus_data = we_q ? wdata_q : {DATA_W{1'bz}};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      last_rd_q   <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      last_rd_q   <= last_rd_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = !req_write ? READ : (last_rd_q && TURNAROUND > 0) ? TURN : WRITE;
          cnt_d   = req_write ? 3'(TURNAROUND) - 3'd1 : 3'(READ_WAIT);
        end
      end
      TURN: begin
        state_d = cnt_q == 3'd0 ? WRITE : TURN;
        cnt_d   = cnt_q - 3'd1;
      end
      WRITE: state_d = IDLE;
      READ: begin
        state_d = cnt_q == 3'd0 ? IDLE : READ;
        cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    addr_d      = accept ? req_addr : addr_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    last_rd_d   = state_q == WRITE ? 1'b0 : done_rd ? 1'b1 : last_rd_q;
    we_d        = state_d == WRITE;
    oe_d        = state_d == READ;
    rsp_valid_d = done_rd;
    rdata_d     = done_rd ? (smp_err ? '0 : bus_data) : rdata_q;
    err_d       = done_rd ? smp_err : err_q;
  end
  always_comb begin
    req_ready = state_q == IDLE;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    bus_addr  = addr_q;
    bus_we    = we_q;
    bus_oe    = oe_q;
  end
endmodule

// File: tb/tb_tristate_bus_master.sv
// tb_tristate_bus_master: directed and random checks of the bus master against a transaction-level model
module tb_tristate_bus_master;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int RW = 1;
  localparam int TA = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req_valid, req_ready, req_write, rsp_valid, rsp_err, bus_we, bus_oe;
  logic [AW-1:0] req_addr, bus_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;
  wire  [DW-1:0] bus_data;
  logic [DW-1:0] mem [4];
  logic bus_is_z;
  assign bus_data = (bus_oe && bus_addr < 4) ? mem[bus_addr[1:0]] : {DW{1'bz}};
  assign bus_is_z = bus_data === {DW{1'bz}};
  always @(posedge clk) begin
    if (rst) for (int k = 0; k < 4; k++) mem[k] <= 8'h10 + 8'(k);
    else if (bus_we && bus_addr < 4) mem[bus_addr[1:0]] <= bus_data;
  end
  tristate_bus_master #(.DATA_W(DW), .ADDR_W(AW), .READ_WAIT(RW), .TURNAROUND(TA)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bus_data(bus_data), .bus_addr(bus_addr), .bus_we(bus_we), .bus_oe(bus_oe)
  );
  logic rst1, v1, ready1, w1, rspv1, err1, we1, oe1;
  logic [AW-1:0] a1, baddr1;
  logic [DW-1:0] wd1, rd1;
  wire  [DW-1:0] bus1;
  assign bus1 = (oe1 && baddr1 == 0) ? 8'h5A : {DW{1'bz}};
  tristate_bus_master #(.DATA_W(DW), .ADDR_W(AW), .READ_WAIT(3), .TURNAROUND(TA)) u1 (
    .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(ready1), .req_write(w1),
    .req_addr(a1), .req_wdata(wd1), .rsp_valid(rspv1), .rsp_rdata(rd1),
    .rsp_err(err1), .bus_data(bus1), .bus_addr(baddr1), .bus_we(we1), .bus_oe(oe1)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_mem [4];
  logic last_rd = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  logic last_err = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic junk(input logic hold);
    if (hold) begin
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
    end
  endtask
  task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic hold);
    logic [DW-1:0] exp_d;
    logic exp_err;
    chk("ready_before_op", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = hold;
    if (w) begin
      if (last_rd) for (int k = 0; k < TA; k++) begin
        junk(hold);
        chk("turn_we", bus_we, 0);
        chk("turn_oe", bus_oe, 0);
        chk("turn_bus_z", bus_is_z, 1);
        chk("turn_addr", bus_addr, a);
        chk("turn_ready", req_ready, 0);
        @(negedge clk);
      end
      junk(hold);
      chk("wr_we", bus_we, 1);
      chk("wr_oe", bus_oe, 0);
      chk("wr_data", bus_data, d);
      chk("wr_addr", bus_addr, a);
      chk("wr_ready", req_ready, 0);
      chk("wr_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      if (a < 4) exp_mem[a[1:0]] = d;
      last_rd = 1'b0;
      chk("wr_done_we", bus_we, 0);
      chk("wr_done_ready", req_ready, 1);
      chk("rdata_held", rsp_rdata, last_rdata);
      chk("err_held", rsp_err, last_err);
    end else begin
      exp_err = a >= 4;
      exp_d   = exp_err ? '0 : exp_mem[a[1:0]];
      for (int k = 0; k <= RW; k++) begin
        junk(hold);
        chk("rd_oe", bus_oe, 1);
        chk("rd_we", bus_we, 0);
        chk("rd_addr", bus_addr, a);
        chk("rd_ready", req_ready, 0);
        chk("rd_rsp_valid_early", rsp_valid, 0);
        if (exp_err) chk("rd_unmapped_z", bus_is_z, 1);
        @(negedge clk);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_ready", req_ready, 1);
      chk("rsp_oe_off", bus_oe, 0);
      last_rd = 1'b1;
      last_rdata = exp_d;
      last_err = exp_err;
    end
  endtask
  initial begin
    rst = 1'b1;
    rst1 = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 4'h7;
    req_wdata = 8'hFF;
    v1 = 1'b0;
    w1 = 1'b0;
    a1 = '0;
    wd1 = '0;
    for (int k = 0; k < 4; k++) exp_mem[k] = 8'h10 + 8'(k);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_we", bus_we, 0);
      chk("rst_oe", bus_oe, 0);
      chk("rst_bus_z", bus_is_z, 1);
      chk("rst_addr", bus_addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
    end
    rst = 1'b0;
    rst1 = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_we", bus_we, 0);
    chk("post_rst_ready", req_ready, 1);
    do_op(1'b1, 4'd2, 8'hA5, 1'b0);
    do_op(1'b0, 4'd2, 8'h00, 1'b0);
    do_op(1'b0, 4'd1, 8'h00, 1'b0);
    do_op(1'b1, 4'd1, 8'h3C, 1'b0);
    do_op(1'b0, 4'd1, 8'h00, 1'b0);
    do_op(1'b0, 4'd9, 8'h00, 1'b0);
    do_op(1'b0, 4'd3, 8'h00, 1'b1);
    do_op(1'b1, 4'd0, 8'h66, 1'b1);
    for (int n = 0; n < 40; n++)
      do_op(1'($urandom), AW'($urandom_range(0, 5)), DW'($urandom), 1'($urandom));
    req_valid = 1'b0;
    @(negedge clk);
    chk("final_idle_we", bus_we, 0);
    chk("final_idle_oe", bus_oe, 0);
    chk("r1_ready", ready1, 1);
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("r1_oe_c1", oe1, 1);
    @(negedge clk);
    chk("r1_oe_c2", oe1, 1);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("r1_oe_reset", oe1, 0);
    chk("r1_ready_reset", ready1, 1);
    for (int c = 0; c < 6; c++) begin
      chk("r1_no_rsp", rspv1, 0);
      @(negedge clk);
    end
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("r1_oe_again", oe1, 1);
      chk("r1_we_off", we1, 0);
      @(negedge clk);
    end
    chk("r1_rsp_valid", rspv1, 1);
    chk("r1_rdata", rd1, 8'h5A);
    chk("r1_err", err1, 0);
    chk("r1_addr", baddr1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
